texture_arbiter: RTL and testbench
==================================

TEXTURE_ARBITER -- requirements
Module: texture_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, texture RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, texel width.
REQ-003 SHALL have parameter LEN, default 16384, number of texels covered by a fill.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port i_rd_valid, input, 1, rasterizer texel read request.
REQ-007 SHALL have port i_rd_address, input, ADDR_W, rasterizer read address.
REQ-008 SHALL have port o_rd_ready, output, 1, rasterizer request granted this cycle.
REQ-009 SHALL have port o_rd_data_valid, output, 1, rasterizer read data valid.
REQ-010 SHALL have port o_rd_data, output, DATA_W, rasterizer read data.
REQ-011 SHALL have port i_host_valid, input, 1, host access request.
REQ-012 SHALL have port i_host_write, input, 1, host request type: 1 = write, 0 = read.
REQ-013 SHALL have port i_host_address, input, ADDR_W, host address.
REQ-014 SHALL have port i_host_data, input, DATA_W, host write data.
REQ-015 SHALL have port o_host_ready, output, 1, host request granted this cycle.
REQ-016 SHALL have port o_host_data_valid, output, 1, host read data valid.
REQ-017 SHALL have port o_host_data, output, DATA_W, host read data.
REQ-018 SHALL have port i_fill_start, input, 1, pulse that starts a whole-memory fill.
REQ-019 SHALL have port i_fill_value, input, DATA_W, fill value, sampled on an accepted i_fill_start.
REQ-020 SHALL have port o_fill_busy, output, 1, fill in progress.
REQ-021 SHALL have ports o_ram_address (ADDR_W), o_ram_data (DATA_W) and o_ram_write_enable (1) as outputs, and i_ram_data (DATA_W) as input, connecting to the single-port texture RAM (1-cycle registered read, no read on a write cycle).

Function
REQ-022 SHALL implement states ARB and FILL.
REQ-023 SHALL, in ARB, transfer a request when its valid and ready are both high; ready is combinational from the valids, the round-robin pointer and the state.
REQ-024 SHALL grant at most one requester per cycle.
REQ-025 SHALL grant a sole requester immediately.
REQ-026 SHALL, when both requesters are valid, grant the one not granted most recently (1-bit round-robin pointer, updated on every grant).
REQ-027 SHALL drive the granted request onto the RAM ports combinationally in the same cycle: o_ram_write_enable = 1 only for a granted host write; otherwise 0.
REQ-028 SHALL assert o_rd_data_valid or o_host_data_valid, registered, for exactly the one cycle after an accepted read of that requester.
REQ-029 SHALL drive o_rd_data and o_host_data combinationally from i_ram_data.
REQ-030 SHALL produce no response for a host write.
REQ-031 SHALL hold readies low and not grant when neither valid is high, and SHALL then keep o_ram_write_enable at 0.
REQ-032 SHALL, on i_fill_start in ARB, take priority over both requesters: no grant that cycle, latch i_fill_value, clear the counter and enter FILL next cycle.
REQ-033 SHALL, in FILL, write the latched value to address = counter each cycle, increment the counter, and hold both readies low.
REQ-034 SHALL keep o_fill_busy high during FILL.
REQ-035 SHALL return to ARB after the write to LEN-1, so a fill takes exactly LEN write cycles.
REQ-036 SHALL ignore i_fill_start while in FILL.
REQ-037 SHALL, in the fill-start cycle, still deliver a read response due from a read accepted in the previous cycle.

Reset
REQ-038 SHALL, while i_reset_n=0 at a clock edge, enter ARB, clear the counter, and deassert o_rd_data_valid, o_host_data_valid, o_fill_busy and o_ram_write_enable.
REQ-039 SHALL, on reset, set the round-robin pointer to "host last", so that the rasterizer wins the first contention.
REQ-040 SHALL, on reset during FILL, abort the fill; RAM contents are left partially filled and are not restored.

Verification
REQ-041 SHALL cover a lone rasterizer read of address 0x0005 holding 0x3C -> o_rd_ready=1 in the same cycle; o_rd_data_valid=1 with o_rd_data=0x3C in the next cycle only.
REQ-042 SHALL cover a host write of 0xA5 to 0x1234, then a host read of 0x1234 -> o_host_data_valid one cycle after the read grant, with o_host_data=0xA5; no response follows the write.
REQ-043 SHALL cover both valids held high for 6 cycles after reset -> grants alternate rasterizer, host, rasterizer, and so on, with never two grants in one cycle.
REQ-044 SHALL cover i_fill_start with i_fill_value=0x7F -> o_fill_busy high for exactly 16384 cycles; readies low throughout; subsequent reads of 0x0000 and 0x3FFF return 0x7F.
REQ-045 SHALL cover i_fill_start in the same cycle as both valids -> neither granted; FILL starts next cycle; pending requests are granted after the fill completes.
REQ-046 SHALL cover i_reset_n=0 at fill cycle 100 -> ARB and o_fill_busy=0 the next cycle; address 0x0063 holds the fill value and 0x0064 holds its old value.

Source files
------------

// File: rtl/texture_arbiter.sv
// Arbiter in front of a single-port texture RAM. It shares the RAM between a
// rasterizer read port and a host read/write port, and can also fill the whole memory.
module texture_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int LEN    = 16384
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_address,
  output logic              o_rd_ready,
  output logic              o_rd_data_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_host_valid,
  input  logic              i_host_write,
  input  logic [ADDR_W-1:0] i_host_address,
  input  logic [DATA_W-1:0] i_host_data,
  output logic              o_host_ready,
  output logic              o_host_data_valid,
  output logic [DATA_W-1:0] o_host_data,
  input  logic              i_fill_start,
  input  logic [DATA_W-1:0] i_fill_value,
  output logic              o_fill_busy,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_write_enable,
  input  logic [DATA_W-1:0] i_ram_data
);

  // state | meaning
  // ARB   | round-robin between rasterizer and host; i_fill_start has priority
  // FILL  | write the latched fill value to address = counter, one per cycle
  typedef enum logic {ARB, FILL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  state_t            state_q, state_d;
  logic              host_last_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              rd_dv_q, host_dv_q;
  logic              rd_grant, host_grant, fill_accept;

  always_comb begin
    state_d            = state_q;
    rd_grant           = 1'b0;
    host_grant         = 1'b0;
    fill_accept        = 1'b0;
    o_ram_address      = '0;
    o_ram_data         = '0;
    o_ram_write_enable = 1'b0;
    case (state_q)
      ARB: begin
        if (i_fill_start) begin
          fill_accept = 1'b1;
          state_d     = FILL;
        end else begin
          rd_grant   = i_reset_n & i_rd_valid & (~i_host_valid | host_last_q);
          host_grant = i_reset_n & i_host_valid & ~rd_grant;
        end
        if (rd_grant) begin
          o_ram_address = i_rd_address;
        end else if (host_grant) begin
          o_ram_address      = i_host_address;
          o_ram_data         = i_host_data;
          o_ram_write_enable = i_host_write;
        end
      end
      FILL: begin
        o_ram_address      = cnt_q;
        o_ram_data         = fill_val_q;
        // reset aborts the fill before the write of the current address lands
        o_ram_write_enable = i_reset_n;
        if (cnt_q == LAST_ADDR) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ARB;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      host_last_q <= 1'b1;
      rd_dv_q     <= 1'b0;
      host_dv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_dv_q   <= rd_grant;
      host_dv_q <= host_grant & ~i_host_write;
      if (rd_grant | host_grant) host_last_q <= host_grant;
      if (fill_accept) begin
        fill_val_q <= i_fill_value;
        cnt_q      <= '0;
      end else if (state_q == FILL) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
    end
  end

  assign o_rd_ready        = rd_grant;
  assign o_host_ready      = host_grant;
  assign o_rd_data_valid   = rd_dv_q;
  assign o_host_data_valid = host_dv_q;
  assign o_rd_data         = i_ram_data;
  assign o_host_data       = i_ram_data;
  assign o_fill_busy       = (state_q == FILL);

endmodule

// File: tb/tb_texture_arbiter.sv
// Randomized scoreboard bench for texture_arbiter, with a behavioural RAM and
// an abstract model of grants, memory contents and fills.
module tb_texture_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int LEN    = 16384;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_rd_valid;
  logic [ADDR_W-1:0] i_rd_address;
  logic              o_rd_ready, o_rd_data_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_host_valid, i_host_write;
  logic [ADDR_W-1:0] i_host_address;
  logic [DATA_W-1:0] i_host_data;
  logic              o_host_ready, o_host_data_valid;
  logic [DATA_W-1:0] o_host_data;
  logic              i_fill_start;
  logic [DATA_W-1:0] i_fill_value;
  logic              o_fill_busy;
  logic [ADDR_W-1:0] o_ram_address;
  logic [DATA_W-1:0] o_ram_data;
  logic              o_ram_write_enable;
  logic [DATA_W-1:0] i_ram_data;

  texture_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN(LEN)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rd_valid(i_rd_valid), .i_rd_address(i_rd_address), .o_rd_ready(o_rd_ready),
    .o_rd_data_valid(o_rd_data_valid), .o_rd_data(o_rd_data),
    .i_host_valid(i_host_valid), .i_host_write(i_host_write),
    .i_host_address(i_host_address), .i_host_data(i_host_data),
    .o_host_ready(o_host_ready), .o_host_data_valid(o_host_data_valid),
    .o_host_data(o_host_data),
    .i_fill_start(i_fill_start), .i_fill_value(i_fill_value), .o_fill_busy(o_fill_busy),
    .o_ram_address(o_ram_address), .o_ram_data(o_ram_data),
    .o_ram_write_enable(o_ram_write_enable), .i_ram_data(i_ram_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DATA_W-1:0] init_val(int a);
    logic [31:0] v;
    v = a;
    if (a == 5) return 8'h3C;
    return v[7:0] ^ v[13:6];
  endfunction

  // texture RAM: registered read, no read on a write cycle
  logic [DATA_W-1:0] ram [LEN];
  bit                ram_wr [LEN];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge i_clk) begin
    if (o_ram_write_enable) begin
      ram[o_ram_address]    <= o_ram_data;
      ram_wr[o_ram_address] <= 1'b1;
    end else begin
      ram_q <= ram_wr[o_ram_address] ? ram[o_ram_address] : init_val(int'(o_ram_address));
    end
  end
  assign i_ram_data = ram_q;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } resp_t;
  resp_t rd_q[$];
  resp_t host_q[$];

  // reference model state
  logic [DATA_W-1:0] m_mem [LEN];
  int                fill_left = 0;
  logic [DATA_W-1:0] fill_val  = '0;
  bit                last_host = 1'b1;
  bit                g_rg, g_hg;
  int                busy_cycles = 0;

  task automatic tick();
    bit exp_rg, exp_hg, exp_we, exp_busy;
    int waddr;
    logic [DATA_W-1:0] wdata;
    @(negedge i_clk);
    exp_rg = 0; exp_hg = 0; exp_we = 0;
    waddr = 0; wdata = '0;
    if (o_fill_busy) busy_cycles++;
    if (!i_reset_n) begin
      fill_left = 0;
      last_host = 1'b1;
    end else begin
      exp_busy = (fill_left > 0);
      if (exp_busy) begin
        waddr = LEN - fill_left;
        wdata = fill_val;
        exp_we = 1;
        m_mem[waddr] = fill_val;
        fill_left--;
      end else if (i_fill_start) begin
        fill_left = LEN;
        fill_val  = i_fill_value;
      end else begin
        if (i_rd_valid && i_host_valid) begin
          exp_rg = last_host;
          exp_hg = !last_host;
        end else begin
          exp_rg = i_rd_valid;
          exp_hg = i_host_valid;
        end
        if (exp_rg) begin
          rd_q.push_back('{cyc + 1, m_mem[i_rd_address]});
          last_host = 1'b0;
        end
        if (exp_hg) begin
          last_host = 1'b1;
          if (i_host_write) begin
            exp_we = 1;
            waddr = int'(i_host_address);
            wdata = i_host_data;
            m_mem[i_host_address] = i_host_data;
          end else begin
            host_q.push_back('{cyc + 1, m_mem[i_host_address]});
          end
        end
      end
      chk("rd_ready", 32'(o_rd_ready), 32'(exp_rg));
      chk("host_ready", 32'(o_host_ready), 32'(exp_hg));
      chk("fill_busy", 32'(o_fill_busy), 32'(exp_busy));
      chk("ram_we", 32'(o_ram_write_enable), 32'(exp_we));
      if (exp_we) begin
        chk("ram_wr_addr", 32'(o_ram_address), 32'(waddr));
        chk("ram_wr_data", 32'(o_ram_data), 32'(wdata));
      end
      if (exp_rg) chk("ram_rd_addr", 32'(o_ram_address), 32'(i_rd_address));
      if (exp_hg && !i_host_write) chk("ram_host_addr", 32'(o_ram_address), 32'(i_host_address));
    end
    g_rg = exp_rg;
    g_hg = exp_hg;
    @(posedge i_clk);
    #1;
  endtask

  // response monitor
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_rd_data_valid) begin
        if (rd_q.size() == 0 || rd_q[0].due != cyc) begin
          chk("rd_unexpected_valid", 32'(1), 32'(0));
        end else begin
          chk("rd_data", 32'(o_rd_data), 32'(rd_q[0].data));
          void'(rd_q.pop_front());
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        chk("rd_missing_valid", 32'(0), 32'(1));
        void'(rd_q.pop_front());
      end
      if (o_host_data_valid) begin
        if (host_q.size() == 0 || host_q[0].due != cyc) begin
          chk("host_unexpected_valid", 32'(1), 32'(0));
        end else begin
          chk("host_data", 32'(o_host_data), 32'(host_q[0].data));
          void'(host_q.pop_front());
        end
      end else if (host_q.size() > 0 && host_q[0].due <= cyc) begin
        chk("host_missing_valid", 32'(0), 32'(1));
        void'(host_q.pop_front());
      end
    end
  end

  task automatic idle(int n);
    i_rd_valid = 0; i_host_valid = 0; i_host_write = 0; i_fill_start = 0;
    repeat (n) tick();
  endtask

  task automatic random_phase(int n);
    repeat (n) begin
      i_rd_valid     = 1'($urandom_range(0, 1));
      i_rd_address   = ($urandom_range(0, 3) == 0) ? 14'h1234 : 14'($urandom_range(0, 15));
      i_host_valid   = 1'($urandom_range(0, 1));
      i_host_write   = 1'($urandom_range(0, 1));
      i_host_address = ($urandom_range(0, 3) == 0) ? 14'h1234 : 14'($urandom_range(0, 15));
      i_host_data    = 8'($urandom);
      tick();
    end
    idle(2);
  endtask

  initial begin
    int b0;
    for (int i = 0; i < LEN; i++) m_mem[i] = init_val(i);
    i_reset_n = 0; i_rd_valid = 0; i_rd_address = '0; i_host_valid = 0;
    i_host_write = 0; i_host_address = '0; i_host_data = '0;
    i_fill_start = 0; i_fill_value = '0;
    @(posedge i_clk);
    #1;
    repeat (3) tick();
    chk("reset_fill_busy", 32'(o_fill_busy), 32'(0));
    chk("reset_rd_dv", 32'(o_rd_data_valid), 32'(0));
    chk("reset_host_dv", 32'(o_host_data_valid), 32'(0));
    chk("reset_ram_we", 32'(o_ram_write_enable), 32'(0));
    i_reset_n = 1;

    // contention straight after reset: rasterizer first, then alternating
    i_rd_valid = 1; i_host_valid = 1; i_host_write = 0;
    for (int i = 0; i < 6; i++) begin
      i_rd_address   = 14'($urandom_range(0, LEN - 1));
      i_host_address = 14'($urandom_range(0, LEN - 1));
      tick();
      chk("alt_rd_grant", 32'(g_rg), 32'((i % 2) == 0));
    end
    idle(2);

    i_rd_valid = 1; i_rd_address = 14'h0005;
    tick();
    idle(3);

    i_host_valid = 1; i_host_write = 1; i_host_address = 14'h1234; i_host_data = 8'hA5;
    tick();
    i_host_write = 0;
    tick();
    idle(3);

    random_phase(400);

    // fill requested together with both valids; requests wait out the fill
    b0 = busy_cycles;
    i_rd_valid = 1; i_rd_address = 14'h0000;
    i_host_valid = 1; i_host_write = 0; i_host_address = 14'h3FFF;
    i_fill_start = 1; i_fill_value = 8'h7F;
    tick();
    chk("fill_start_no_grant", 32'(g_rg | g_hg), 32'(0));
    for (int i = 0; i < LEN + 20; i++) begin
      i_fill_start = (i == 5000);
      i_fill_value = (i == 5000) ? 8'h11 : 8'h7F;
      tick();
      if (g_rg) i_rd_valid = 0;
      if (g_hg) i_host_valid = 0;
      if (!i_rd_valid && !i_host_valid) break;
    end
    chk("pending_after_fill", 32'(i_rd_valid | i_host_valid), 32'(0));
    idle(3);
    chk("fill_busy_cycles", 32'(busy_cycles - b0), 32'(LEN));

    random_phase(200);

    // reset at fill cycle 100 aborts the fill
    i_fill_start = 1; i_fill_value = 8'h5A;
    tick();
    i_fill_start = 0;
    repeat (100) tick();
    i_reset_n = 0;
    tick();
    i_reset_n = 1;
    chk("abort_fill_busy", 32'(o_fill_busy), 32'(0));
    tick();
    i_rd_valid = 1; i_rd_address = 14'h0063;
    tick();
    i_rd_address = 14'h0064;
    tick();
    i_rd_valid = 0;
    i_host_valid = 1; i_host_write = 0; i_host_address = 14'h0063;
    tick();
    idle(4);

    chk("queues_drained", 32'(rd_q.size() + host_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
